// File: rtl/multicycle_control_fsm_if.sv
// Signal bundle between the multi-cycle controller and the LEGv8 datapath/memory port.
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ack;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        memread;
  logic        memwrite;
  logic        iord;
  logic        regwrite;
  logic        reg2loc;
  logic        alusrc;
  logic        mem2reg;
  logic [3:0]  aluop;
  logic [2:0]  signop;
  logic [2:0]  state;
  logic        fault;

  modport master (
    input  opcode, zero, mem_ack,
    output ir_write, pc_write, pc_src, memread, memwrite, iord, regwrite,
           reg2loc, alusrc, mem2reg, aluop, signop, state, fault
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  ir_write, pc_write, pc_src, memread, memwrite, iord, regwrite,
           reg2loc, alusrc, mem2reg, aluop, signop, state, fault
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 sequencing controller: FETCH/DECODE/EXEC/MEM/WB with a shared
// memory port (req/ack + timeout) and sticky fault on illegal opcode or timeout.
//
//  state  | meaning
//  FETCH  | instruction read from PC address, wait for mem_ack, load IR
//  DECODE | classify opcode from IR; illegal opcode halts
//  EXEC   | ALU op; branches update PC and retire here
//  MEM    | data read (LDUR) or write (STUR) at ALU address, wait for mem_ack
//  WB     | register write + PC+4 for one cycle
//  HALT   | fault stop, left only through reset
module multicycle_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input logic                      CLK,
  input logic                      resetl,
  multicycle_control_fsm_if.master bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ANDREG, C_ORRREG, C_ADDREG, C_SUBREG, C_ADDIMM, C_SUBIMM,
    C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR, C_ILLEGAL
  } cls_t;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic [3:0] aluop;
    logic [2:0] signop;
  } ctl_t;

  state_t        st;
  cls_t          cls;
  ctl_t          ctl_q;
  logic [CW-1:0] wait_cnt;
  logic          fault_q;
  logic          rd_q;
  logic          wr_q;
  logic          iord_q;
  cls_t          dec_cls;
  logic          wait_expired;

  // Priority-ordered opcode classification, same table as the single-cycle decode.
  function automatic cls_t classify(input logic [10:0] op);
    casez (op)
      11'b?0001010???: classify = C_ANDREG;
      11'b?0101010???: classify = C_ORRREG;
      11'b?0?01011???: classify = C_ADDREG;
      11'b?1?01011???: classify = C_SUBREG;
      11'b?0?10001???: classify = C_ADDIMM;
      11'b?1?10001???: classify = C_SUBIMM;
      11'b110100101??: classify = C_MOVZ;
      11'b?00101?????: classify = C_B;
      11'b?011010????: classify = C_CBZ;
      11'b??111000010: classify = C_LDUR;
      11'b??111000000: classify = C_STUR;
      default:         classify = C_ILLEGAL;
    endcase
  endfunction

  // Datapath selects per class; MOVZ takes its shift selector from the opcode.
  function automatic ctl_t ctl_of(input cls_t c, input logic [2:0] mv);
    ctl_t r;
    r = '0;
    case (c)
      C_ANDREG: r.aluop = 4'b0000;
      C_ORRREG: r.aluop = 4'b0001;
      C_ADDREG: r.aluop = 4'b0010;
      C_SUBREG: r.aluop = 4'b0110;
      C_ADDIMM: begin r.alusrc = 1'b1; r.aluop = 4'b0010; end
      C_SUBIMM: begin r.alusrc = 1'b1; r.aluop = 4'b0110; end
      C_MOVZ:   begin r.alusrc = 1'b1; r.aluop = 4'b0111; r.signop = mv; end
      C_B:      r.signop = 3'b010;
      C_CBZ:    begin r.reg2loc = 1'b1; r.aluop = 4'b0111; r.signop = 3'b011; end
      C_LDUR:   begin r.alusrc = 1'b1; r.mem2reg = 1'b1; r.aluop = 4'b0010; r.signop = 3'b001; end
      C_STUR:   begin r.reg2loc = 1'b1; r.alusrc = 1'b1; r.aluop = 4'b0010; r.signop = 3'b001; end
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign dec_cls      = classify(bus.opcode);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // State sequencing, wait counter, class latch and registered request/select levels.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      st       <= S_FETCH;
      cls      <= C_NONE;
      ctl_q    <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b0;
      iord_q   <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (bus.mem_ack) begin
            st   <= S_DECODE;
            rd_q <= 1'b0;
          end else if (wait_expired) begin
            st      <= S_HALT;
            fault_q <= 1'b1;
            rd_q    <= 1'b0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == C_ILLEGAL) begin
            st      <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            st    <= S_EXEC;
            ctl_q <= ctl_of(dec_cls, bus.opcode[2:0]);
          end
        end
        S_EXEC: begin
          case (cls)
            C_B, C_CBZ: begin
              st       <= S_FETCH;
              rd_q     <= 1'b1;
              wait_cnt <= '0;
              ctl_q    <= '0;
            end
            C_LDUR: begin
              st       <= S_MEM;
              rd_q     <= 1'b1;
              iord_q   <= 1'b1;
              wait_cnt <= '0;
            end
            C_STUR: begin
              st       <= S_MEM;
              wr_q     <= 1'b1;
              iord_q   <= 1'b1;
              wait_cnt <= '0;
            end
            default: st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            iord_q <= 1'b0;
            if (cls == C_STUR) begin
              st       <= S_FETCH;
              rd_q     <= 1'b1;
              wait_cnt <= '0;
              ctl_q    <= '0;
            end else begin
              st <= S_WB;
            end
          end else if (wait_expired) begin
            st      <= S_HALT;
            fault_q <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            iord_q  <= 1'b0;
            ctl_q   <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          st       <= S_FETCH;
          rd_q     <= 1'b1;
          wait_cnt <= '0;
          ctl_q    <= '0;
        end
        default: begin
          st     <= S_HALT;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          iord_q <= 1'b0;
          ctl_q  <= '0;
        end
      endcase
    end
  end

  // Ack-qualified strobes are formed from the registered state; everything reads 0 in reset.
  assign bus.memread  = resetl & rd_q;
  assign bus.memwrite = resetl & wr_q;
  assign bus.iord     = resetl & iord_q;
  assign bus.ir_write = resetl & (st == S_FETCH) & bus.mem_ack;
  assign bus.regwrite = resetl & (st == S_WB);
  assign bus.pc_write = resetl & ((st == S_WB)
                                  | ((st == S_EXEC) & ((cls == C_B) | (cls == C_CBZ)))
                                  | ((st == S_MEM) & (cls == C_STUR) & bus.mem_ack));
  assign bus.pc_src   = resetl & (st == S_EXEC) & ((cls == C_B) | ((cls == C_CBZ) & bus.zero));
  assign bus.reg2loc  = resetl & ctl_q.reg2loc;
  assign bus.alusrc   = resetl & ctl_q.alusrc;
  assign bus.mem2reg  = resetl & ctl_q.mem2reg;
  assign bus.aluop    = resetl ? ctl_q.aluop : 4'b0000;
  assign bus.signop   = resetl ? ctl_q.signop : 3'b000;
  assign bus.state    = resetl ? st : S_FETCH;
  assign bus.fault    = resetl & fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multi-cycle controller (TIMEOUT=4). Inputs change on the
// falling edge; outputs are checked 1 time unit later, well away from the rising edge.
module tb_multicycle_control_fsm;

  logic CLK = 1'b0;
  logic resetl;
  int   checks = 0;
  int   errors = 0;

  // strobe vector order: {ir_write, pc_write, pc_src, memread, memwrite, iord, regwrite}
  localparam logic [6:0] SB_NONE = 7'b0000000;
  localparam logic [6:0] SB_FET  = 7'b0001000;
  localparam logic [6:0] SB_IRW  = 7'b1001000;
  localparam logic [6:0] SB_WB   = 7'b0100001;
  localparam logic [6:0] SB_BR   = 7'b0110000;
  localparam logic [6:0] SB_NT   = 7'b0100000;
  localparam logic [6:0] SB_MRD  = 7'b0001010;
  localparam logic [6:0] SB_MWR  = 7'b0000110;
  localparam logic [6:0] SB_STA  = 7'b0100110;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.TIMEOUT(4)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] strb();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.memread,
            bus.memwrite, bus.iord, bus.regwrite};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // set ack/zero for this cycle and let combinational outputs settle
  task automatic drive(input logic ack, input logic z);
    bus.mem_ack = ack;
    bus.zero    = z;
    #1;
  endtask

  initial begin
    resetl      = 1'b0;
    bus.opcode  = OP_ADD;
    bus.zero    = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    drive(1'b1, 1'b0);
    chk("rst_strb",  strb(),            SB_NONE);
    chk("rst_state", 7'(bus.state),     7'd0);
    chk("rst_fault", 7'(bus.fault),     7'd0);
    chk("rst_aluop", 7'(bus.aluop),     7'd0);
    resetl = 1'b1;
    drive(1'b0, 1'b0);
    chk("fetch_idle", strb(), SB_FET);

    // ADD, zero-wait fetch: states 0,1,2,4
    bus.opcode = OP_ADD;
    drive(1'b1, 1'b0);
    chk("add_fetch", strb(), SB_IRW);
    tick(); drive(1'b0, 1'b0);
    chk("add_dec_state", 7'(bus.state), 7'd1);
    chk("add_dec_strb",  strb(),        SB_NONE);
    tick(); drive(1'b0, 1'b0);
    chk("add_exec_state", 7'(bus.state), 7'd2);
    chk("add_exec_aluop", 7'(bus.aluop), 7'b0010);
    chk("add_exec_strb",  strb(),        SB_NONE);
    tick(); drive(1'b0, 1'b0);
    chk("add_wb_state", 7'(bus.state), 7'd4);
    chk("add_wb_strb",  strb(),        SB_WB);
    chk("add_wb_aluop", 7'(bus.aluop), 7'b0010);
    tick(); drive(1'b0, 1'b0);
    chk("add_back_fetch", 7'(bus.state), 7'd0);

    // LDUR: data ack after 3 waits
    bus.opcode = OP_LDUR;
    drive(1'b1, 1'b0);
    chk("ld_fetch", strb(), SB_IRW);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0);
    chk("ld_exec_state", 7'(bus.state), 7'd2);
    chk("ld_exec_signop", 7'(bus.signop), 7'b001);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 1'b0);
      chk("ld_mem_wait_strb",  strb(),        SB_MRD);
      chk("ld_mem_wait_state", 7'(bus.state), 7'd3);
    end
    tick(); drive(1'b1, 1'b0);
    chk("ld_mem_ack_strb", strb(), SB_MRD);
    tick(); drive(1'b0, 1'b0);
    chk("ld_wb_state",   7'(bus.state),   7'd4);
    chk("ld_wb_strb",    strb(),          SB_WB);
    chk("ld_wb_mem2reg", 7'(bus.mem2reg), 7'd1);
    tick(); drive(1'b0, 1'b0);
    chk("ld_back_fetch", 7'(bus.state), 7'd0);

    // CBZ taken then not taken
    bus.opcode = OP_CBZ;
    drive(1'b1, 1'b0);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b1);
    chk("cbz1_strb",  strb(),        SB_BR);
    chk("cbz1_aluop", 7'(bus.aluop), 7'b0111);
    tick(); drive(1'b1, 1'b0);
    chk("cbz1_next_state", 7'(bus.state), 7'd0);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0);
    chk("cbz0_strb",  strb(),        SB_NT);
    chk("cbz0_state", 7'(bus.state), 7'd2);

    // B with fetch ack arriving on the last allowed cycle
    bus.opcode = OP_B;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      chk("b_fetch_wait", strb(), SB_FET);
      tick();
    end
    drive(1'b1, 1'b0);
    chk("b_fetch_last_ack", strb(), SB_IRW);
    tick(); drive(1'b0, 1'b0);
    chk("b_dec_state", 7'(bus.state), 7'd1);
    chk("b_dec_fault", 7'(bus.fault), 7'd0);
    tick(); drive(1'b0, 1'b0);
    chk("b_exec_strb", strb(), SB_BR);

    // STUR completes with zero-wait ack
    bus.opcode = OP_STUR;
    tick(); drive(1'b1, 1'b0);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0);
    chk("st_exec_reg2loc", 7'(bus.reg2loc), 7'd1);
    tick(); drive(1'b1, 1'b0);
    chk("st_mem_ack_strb", strb(), SB_STA);
    tick(); drive(1'b0, 1'b0);
    chk("st_back_fetch", 7'(bus.state), 7'd0);

    // STUR aborted by reset while in MEM
    drive(1'b1, 1'b0);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0);
    chk("st2_mem_strb", strb(), SB_MWR);
    resetl = 1'b0;
    drive(1'b0, 1'b0);
    chk("st2_rst_strb", strb(), SB_NONE);
    tick();
    resetl = 1'b1;
    drive(1'b0, 1'b0);
    chk("st2_rel_state", 7'(bus.state), 7'd0);
    chk("st2_rel_fault", 7'(bus.fault), 7'd0);
    chk("st2_rel_strb",  strb(),        SB_FET);

    // fetch timeout: 4 request cycles then HALT
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 1'b0);
      chk("to_wait_strb", strb(), SB_FET);
    end
    tick(); drive(1'b0, 1'b0);
    chk("to_halt_state", 7'(bus.state), 7'd7);
    chk("to_halt_fault", 7'(bus.fault), 7'd1);
    chk("to_halt_strb",  strb(),        SB_NONE);
    bus.opcode = OP_ADD;
    tick(); drive(1'b1, 1'b0);
    chk("to_halt_ack_strb", strb(), SB_NONE);

    // illegal opcode halts from DECODE; later acks do nothing
    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    bus.opcode = OP_BAD;
    drive(1'b1, 1'b0);
    chk("ill_fetch", strb(), SB_IRW);
    tick(); drive(1'b1, 1'b0);
    chk("ill_dec_state", 7'(bus.state), 7'd1);
    chk("ill_dec_strb",  strb(),        SB_NONE);
    tick(); drive(1'b1, 1'b0);
    chk("ill_halt_state", 7'(bus.state), 7'd7);
    chk("ill_halt_fault", 7'(bus.fault), 7'd1);
    bus.opcode = OP_LDUR;
    tick(); drive(1'b1, 1'b1);
    chk("ill_halt_strb", strb(),        SB_NONE);
    chk("ill_halt_sticky", 7'(bus.fault), 7'd1);
    resetl = 1'b0;
    tick();
    resetl = 1'b1;
    drive(1'b0, 1'b0);
    chk("final_fault", 7'(bus.fault), 7'd0);
    chk("final_strb",  strb(),        SB_FET);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
